// File: rtl/roi_bbox_tracker.sv
// roi_bbox_tracker: per-frame far corner (T_x, T_y) of mask hits inside a fixed ROI.
// Define HIT_COUNT_EN to add a saturating hit counter, MIN_HITS qualification and hit_cnt.
module roi_bbox_tracker #(
   parameter logic [10:0] X1 = 11'd181,
   parameter logic [10:0] X2 = 11'd331,
   parameter logic [9:0]  Y1 = 10'd121,
   parameter logic [9:0]  Y2 = 10'd220
`ifdef HIT_COUNT_EN
   ,
   parameter logic [20:0] MIN_HITS = 21'd1
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        sof,
   input  logic        eof,
   input  logic [10:0] pix_x,
   input  logic [9:0]  pix_y,
   input  logic        mask,
   output logic [10:0] T_x,
   output logic [9:0]  T_y,
   output logic        upd,
   output logic        object_present
`ifdef HIT_COUNT_EN
   ,
   output logic [20:0] hit_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_e;

   state_e      state_q;
   logic [10:0] max_x_q;
   logic [9:0]  max_y_q;
   logic        pending_q;
`ifdef HIT_COUNT_EN
   logic [20:0] cnt_q;
`else
   logic        hit_q;
`endif

   logic pix_hit;
   logic start;
   logic qualify;

   assign pix_hit = en & mask & (pix_x >= X1) & (pix_x <= X2) & (pix_y >= Y1) & (pix_y <= Y2);

   // A new frame opens from IDLE on sof, on a lone sof mid-frame, or straight out of PUBLISH.
   assign start = ((state_q == IDLE) & sof)
                | ((state_q == ACCUM) & sof & ~eof)
                | ((state_q == PUBLISH) & (pending_q | sof));

`ifdef HIT_COUNT_EN
   assign qualify = (cnt_q >= MIN_HITS);
`else
   assign qualify = hit_q;
`endif

   // NOTE: sequential state uses non-blocking assignments only; later assignments in the
   // same block override earlier ones, which is how a frame start wins over accumulation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         max_x_q        <= '0;
         max_y_q        <= '0;
         pending_q      <= 1'b0;
         T_x            <= '0;
         T_y            <= '0;
         upd            <= 1'b0;
         object_present <= 1'b0;
`ifdef HIT_COUNT_EN
         cnt_q          <= '0;
         hit_cnt        <= '0;
`else
         hit_q          <= 1'b0;
`endif
      end else begin
         upd <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sof) state_q <= ACCUM;
            end
            ACCUM: begin
               if (pix_hit) begin
                  if (pix_x > max_x_q) max_x_q <= pix_x;
                  if (pix_y > max_y_q) max_y_q <= pix_y;
`ifdef HIT_COUNT_EN
                  if (cnt_q != '1) cnt_q <= cnt_q + 21'd1;
`else
                  hit_q <= 1'b1;
`endif
               end
               if (eof) begin
                  state_q   <= PUBLISH;
                  pending_q <= sof;
               end
            end
            PUBLISH: begin
               upd            <= 1'b1;
               object_present <= qualify;
               T_x            <= qualify ? max_x_q : 11'd0;
               T_y            <= qualify ? max_y_q : 10'd0;
`ifdef HIT_COUNT_EN
               hit_cnt        <= cnt_q;
`endif
               pending_q      <= 1'b0;
               state_q        <= (pending_q | sof) ? ACCUM : IDLE;
            end
            default: state_q <= IDLE;
         endcase

         if (start) begin
            max_x_q <= X1;
            max_y_q <= Y1;
`ifdef HIT_COUNT_EN
            cnt_q   <= '0;
`else
            hit_q   <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_roi_bbox_tracker.sv
// Directed bench for roi_bbox_tracker: table of frames plus hand-written restart/reset sequences.
// Builds with or without HIT_COUNT_EN (MIN_HITS=3 when defined).
module tb_roi_bbox_tracker;

`ifdef HIT_COUNT_EN
   localparam int MIN_REQ = 3;
`else
   localparam int MIN_REQ = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        en, sof, eof, mask;
   logic [10:0] pix_x;
   logic [9:0]  pix_y;
   logic [10:0] T_x;
   logic [9:0]  T_y;
   logic        upd;
   logic        object_present;
`ifdef HIT_COUNT_EN
   logic [20:0] hit_cnt;
`endif

   int vectors = 0;
   int fails   = 0;

   always #5 clk = ~clk;

`ifdef HIT_COUNT_EN
   roi_bbox_tracker #(.MIN_HITS(21'd3)) dut (
`else
   roi_bbox_tracker dut (
`endif
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .sof            (sof),
      .eof            (eof),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .mask           (mask),
      .T_x            (T_x),
      .T_y            (T_y),
      .upd            (upd),
      .object_present (object_present)
`ifdef HIT_COUNT_EN
      ,
      .hit_cnt        (hit_cnt)
`endif
   );

   // Up to four pixels per frame; ex/ey is the hand-computed far corner, n the in-ROI hit count.
   typedef struct packed {
      logic [3:0]        en;
      logic [3:0]        mk;
      logic [3:0][10:0]  px;
      logic [3:0][9:0]   py;
      logic [10:0]       ex;
      logic [9:0]        ey;
      logic [7:0]        n;
   } vec_t;

   localparam int NVEC = 7;
   vec_t vecs[NVEC];

   task automatic check(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic e, input logic m, input logic [10:0] x, input logic [9:0] y,
                       input logic s, input logic f);
      en = e; mask = m; pix_x = x; pix_y = y; sof = s; eof = f;
      cyc();
      en = 1'b0; mask = 1'b0; sof = 1'b0; eof = 1'b0;
   endtask

   task automatic add_pix(input int v, input int i, input logic e, input logic m,
                          input logic [10:0] x, input logic [9:0] y);
      vecs[v].en[i] = e;
      vecs[v].mk[i] = m;
      vecs[v].px[i] = x;
      vecs[v].py[i] = y;
   endtask

   task automatic set_exp(input int v, input logic [10:0] x, input logic [9:0] y, input int n);
      vecs[v].ex = x;
      vecs[v].ey = y;
      vecs[v].n  = 8'(n);
   endtask

   // Called right after the edge that sampled eof: PUBLISH is current, results land one edge later.
   task automatic expect_pub(input string nm, input int ex, input int ey, input int n);
      logic q;
      q = (n >= MIN_REQ);
      check({nm, " upd before publish"}, int'(upd), 0);
      cyc();
      check({nm, " upd"}, int'(upd), 1);
      check({nm, " T_x"}, int'(T_x), q ? ex : 0);
      check({nm, " T_y"}, int'(T_y), q ? ey : 0);
      check({nm, " object_present"}, int'(object_present), int'(q));
`ifdef HIT_COUNT_EN
      check({nm, " hit_cnt"}, int'(hit_cnt), n);
`endif
      cyc();
      check({nm, " upd one-shot"}, int'(upd), 0);
   endtask

   initial begin
      logic saw_upd;
      int   last_x, last_y;

      en = 1'b0; sof = 1'b0; eof = 1'b0; mask = 1'b0; pix_x = '0; pix_y = '0;
      reset = 1'b1;

      foreach (vecs[i]) vecs[i] = '0;
      add_pix(0, 0, 1, 1, 11'd200, 10'd130);
      add_pix(0, 1, 1, 1, 11'd300, 10'd210);
      add_pix(0, 2, 1, 1, 11'd250, 10'd150);
      set_exp(0, 11'd300, 10'd210, 3);
      add_pix(1, 0, 1, 1, 11'd100, 10'd100);
      add_pix(1, 1, 1, 1, 11'd400, 10'd230);
      set_exp(1, 11'd0, 10'd0, 0);
      add_pix(2, 0, 1, 1, 11'd331, 10'd220);
      add_pix(2, 1, 1, 1, 11'd181, 10'd121);
      add_pix(2, 2, 1, 1, 11'd332, 10'd221);
      set_exp(2, 11'd331, 10'd220, 2);
      add_pix(3, 0, 1, 1, 11'd181, 10'd121);
      set_exp(3, 11'd181, 10'd121, 1);
      add_pix(4, 0, 1, 0, 11'd300, 10'd200);
      add_pix(4, 1, 0, 1, 11'd310, 10'd210);
      set_exp(4, 11'd0, 10'd0, 0);
      add_pix(5, 0, 1, 1, 11'd180, 10'd200);
      add_pix(5, 1, 1, 1, 11'd250, 10'd120);
      add_pix(5, 2, 1, 1, 11'd332, 10'd150);
      add_pix(5, 3, 1, 1, 11'd250, 10'd221);
      set_exp(5, 11'd0, 10'd0, 0);
      add_pix(6, 0, 1, 1, 11'd182, 10'd219);
      add_pix(6, 1, 1, 1, 11'd200, 10'd122);
      set_exp(6, 11'd200, 10'd219, 2);

      cyc();
      cyc();
      check("reset T_x", int'(T_x), 0);
      check("reset T_y", int'(T_y), 0);
      check("reset upd", int'(upd), 0);
      check("reset object_present", int'(object_present), 0);
      reset = 1'b0;
      cyc();

      for (int v = 0; v < NVEC; v++) begin
         step(1'b0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
         for (int i = 0; i < 4; i++)
            step(vecs[v].en[i], vecs[v].mk[i], vecs[v].px[i], vecs[v].py[i], 1'b0, 1'b0);
         step(1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1);
         expect_pub($sformatf("vec%0d", v), int'(vecs[v].ex), int'(vecs[v].ey), int'(vecs[v].n));
      end

      // Published values hold through idle cycles.
      last_x = (int'(vecs[NVEC-1].n) >= MIN_REQ) ? int'(vecs[NVEC-1].ex) : 0;
      last_y = (int'(vecs[NVEC-1].n) >= MIN_REQ) ? int'(vecs[NVEC-1].ey) : 0;
      for (int i = 0; i < 3; i++) cyc();
      check("hold T_x", int'(T_x), last_x);
      check("hold T_y", int'(T_y), last_y);

      // Mid-frame sof discards the earlier hit.
      step(1'b0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 11'd320, 10'd200, 1'b0, 1'b0);
      step(1'b0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 11'd190, 10'd125, 1'b0, 1'b0);
      step(1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1);
      expect_pub("restart", 190, 125, 1);

      // sof+eof together: the hit in that cycle counts, and the next frame opens without sof.
      step(1'b0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 11'd200, 10'd150, 1'b0, 1'b0);
      step(1'b1, 1'b1, 11'd210, 10'd160, 1'b1, 1'b1);
      expect_pub("sof_eof", 210, 160, 2);
      step(1'b1, 1'b1, 11'd190, 10'd130, 1'b0, 1'b0);
      step(1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1);
      expect_pub("chained", 190, 130, 1);

      // Publish a visible box, then reset asynchronously in the middle of the next frame.
      step(1'b0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 11'd250, 10'd180, 1'b0, 1'b0);
      step(1'b1, 1'b1, 11'd260, 10'd190, 1'b0, 1'b0);
      step(1'b1, 1'b1, 11'd270, 10'd200, 1'b0, 1'b0);
      step(1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1);
      expect_pub("pre_reset", 270, 200, 3);
      step(1'b0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 11'd300, 10'd200, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("async reset T_x", int'(T_x), 0);
      check("async reset T_y", int'(T_y), 0);
      check("async reset object_present", int'(object_present), 0);
      #1 reset = 1'b0;
      cyc();
      step(1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1);
      saw_upd = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (upd) saw_upd = 1'b1;
         cyc();
      end
      check("no upd after reset", int'(saw_upd), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
